// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, constants and saturation helper for the biquad sequencer
package iir_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OUT_W_DEF  = 18;
  localparam int COEF_W_DEF = 10;
  localparam int FRAC_DEF   = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int NTAPS      = 5;

  localparam logic [2:0] CA_B0 = 3'd0;
  localparam logic [2:0] CA_B1 = 3'd1;
  localparam logic [2:0] CA_B2 = 3'd2;
  localparam logic [2:0] CA_A1 = 3'd3;
  localparam logic [2:0] CA_A2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Clamp a signed accumulator-width value into a signed range of the given width.
  function automatic logic signed [ACC_W_DEF-1:0] saturate(
    input logic signed [ACC_W_DEF-1:0] value,
    input int                          width
  );
    logic signed [ACC_W_DEF-1:0] hi;
    logic signed [ACC_W_DEF-1:0] lo;
    hi = $signed((ACC_W_DEF'(1) << (width - 1)) - ACC_W_DEF'(1));
    lo = ~hi;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared signed multiply-accumulate with registered accumulator
module iir_mac
  import iir_pkg::*;
#(
  parameter int OUT_W  = OUT_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic                     sub_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [OUT_W-1:0]  op_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PW = COEF_W + OUT_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod     = coef_i * op_i;
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/iir_biquad_sequencer.sv
// rtl/iir_biquad_sequencer.sv - direct-form-I biquad sequencing one MAC over five taps per sample
module iir_biquad_sequencer
  import iir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  data_out,
  output logic                     out_valid,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  input  logic                     flush,
  output logic                     sat_flag
);

  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);

  state_e                    state_q, state_d;
  logic [2:0]                tap_q, tap_d;
  logic signed [OUT_W-1:0]   x_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [COEF_W-1:0]  act_q [NTAPS];
  logic signed [COEF_W-1:0]  shd_q [NTAPS];
  logic signed [OUT_W-1:0]   dout_q;
  logic                      oval_q, sat_q;
  logic                      accept, mac_en, mac_sub, clamp;
  logic signed [COEF_W-1:0]  mac_coef;
  logic signed [OUT_W-1:0]   mac_op, y_new;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W_DEF-1:0] acc_shr, y_sat;

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst && !flush;
        accept   = in_ready && in_valid;
        if (accept) begin
          state_d = MAC;
          tap_d   = 3'd0;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        tap_d  = tap_q + 3'd1;
        if (tap_q == CA_A2) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Feedback taps subtract so coefficients keep their textbook sign.
  always_comb begin
    mac_op   = x_q;
    mac_coef = act_q[0];
    mac_sub  = 1'b0;
    case (tap_q)
      CA_B1: begin mac_op = x1_q; mac_coef = act_q[1]; end
      CA_B2: begin mac_op = x2_q; mac_coef = act_q[2]; end
      CA_A1: begin mac_op = y1_q; mac_coef = act_q[3]; mac_sub = 1'b1; end
      CA_A2: begin mac_op = y2_q; mac_coef = act_q[4]; mac_sub = 1'b1; end
      default: begin mac_op = x_q; mac_coef = act_q[0]; end
    endcase
  end

  iir_mac #(
    .OUT_W (OUT_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear_i(accept),
    .en_i   (mac_en),
    .sub_i  (mac_sub),
    .coef_i (mac_coef),
    .op_i   (mac_op),
    .acc_o  (acc)
  );

  assign acc_shr = ACC_W_DEF'(acc >>> FRAC);
  assign y_sat   = saturate(acc_shr, OUT_W);
  assign clamp   = (y_sat != acc_shr);
  assign y_new   = y_sat[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      dout_q  <= '0;
      oval_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        act_q[i] <= (i == 0) ? COEF_ONE : '0;
        shd_q[i] <= (i == 0) ? COEF_ONE : '0;
      end
    end else begin
      oval_q <= 1'b0;
      if (cfg_we && (cfg_addr <= CA_A2)) shd_q[cfg_addr] <= cfg_data;
      if (flush) begin
        state_q <= IDLE;
        tap_q   <= '0;
        x1_q    <= '0;
        x2_q    <= '0;
        y1_q    <= '0;
        y2_q    <= '0;
        sat_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        tap_q   <= tap_d;
        if (accept) begin
          x_q   <= {{(OUT_W - DATA_W){data_in[DATA_W-1]}}, data_in};
          act_q <= shd_q;
        end
        if (state_q == DONE) begin
          dout_q <= y_new;
          oval_q <= 1'b1;
          if (clamp) sat_q <= 1'b1;
          x2_q <= x1_q;
          x1_q <= x_q;
          y2_q <= y1_q;
          y1_q <= y_new;
        end
      end
    end
  end

  assign data_out  = dout_q;
  assign out_valid = oval_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// tb/tb_iir_biquad_sequencer.sv - directed self-checking bench for the biquad sequencer
module tb_iir_biquad_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [7:0]  data_in;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] data_out;
  logic               out_valid;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic signed [9:0]  cfg_data;
  logic               flush;
  logic               sat_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iir_biquad_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .flush    (flush),
    .sat_flag (sat_flag)
  );

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input int v);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = a; cfg_data = 10'(v);
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic accept_sample(input int v);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; data_in = 8'(v);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic signed [17:0] y, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    y = out_valid ? data_out : 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1; data_in = '0; in_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    total++; if (data_out !== 18'sd0) begin bad++; $display("FAIL reset_data_out got %0d expected 0", data_out); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag got %b expected 0", sat_flag); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_passthrough();
    logic signed [17:0] y;
    int lat;
    accept_sample(-6);
    wait_out(y, lat);
    total++; if (y !== 18'h3FFFA) begin bad++; $display("FAIL pass_value got %0d expected -6", y); end
    total++; if (lat !== 6) begin bad++; $display("FAIL pass_latency got %0d expected 6", lat); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_ready_with_out got %b expected 1", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_pulse_width got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic signed [17:0] outs [2];
    int acc_t [2];
    int n_acc = 0;
    int n_out = 0;
    outs[0] = 'x; outs[1] = 'x; acc_t[0] = -100; acc_t[1] = 0;
    write_coef(3'd0, 128);
    write_coef(3'd1, 128);
    do_flush();
    in_valid = 1'b1; data_in = 8'sd100;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      #1;
      if (out_valid) begin outs[n_out] = data_out; n_out++; end
      if (in_valid && in_ready && n_acc < 2) begin acc_t[n_acc] = i; n_acc++; end
      @(posedge clk);
      @(negedge clk);
      if (n_acc == 1) data_in = 8'sd20;
      if (n_acc == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++; if (outs[0] !== 18'sd50) begin bad++; $display("FAIL b2b_out0 got %0d expected 50", outs[0]); end
    total++; if (outs[1] !== 18'sd60) begin bad++; $display("FAIL b2b_out1 got %0d expected 60", outs[1]); end
    total++; if (acc_t[1] - acc_t[0] !== 7) begin bad++; $display("FAIL b2b_interval got %0d expected 7", acc_t[1] - acc_t[0]); end
  endtask

  task automatic test_feedback();
    logic signed [17:0] y;
    int lat;
    int xs [3] = '{64, 0, 0};
    int ex [3] = '{64, 32, 16};
    write_coef(3'd0, 256);
    write_coef(3'd1, 0);
    write_coef(3'd3, -128);
    do_flush();
    for (int k = 0; k < 3; k++) begin
      accept_sample(xs[k]);
      wait_out(y, lat);
      total++; if (y !== 18'(ex[k])) begin bad++; $display("FAIL fb_out%0d got %0d expected %0d", k, y, ex[k]); end
    end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL fb_sat got %b expected 0", sat_flag); end
  endtask

  task automatic test_saturation();
    logic signed [17:0] y;
    int lat;
    longint yp = 0;
    longint ye;
    logic exp_sat = 1'b0;
    write_coef(3'd0, 511);
    write_coef(3'd3, -511);
    do_flush();
    for (int k = 0; k < 10; k++) begin
      ye = (511 * 127 + 511 * yp) >>> 8;
      if (ye > 131071) begin ye = 131071; exp_sat = 1'b1; end
      accept_sample(127);
      wait_out(y, lat);
      total++; if (y !== 18'(ye)) begin bad++; $display("FAIL sat_out%0d got %0d expected %0d", k, y, ye); end
      @(negedge clk);
      total++; if (sat_flag !== exp_sat) begin bad++; $display("FAIL sat_flag%0d got %b expected %b", k, sat_flag, exp_sat); end
      yp = ye;
    end
    do_flush();
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_flush_clear got %b expected 0", sat_flag); end
    total++; if (data_out !== 18'sd131071) begin bad++; $display("FAIL sat_flush_hold got %0d expected 131071", data_out); end
  endtask

  task automatic test_coef_shadow();
    logic signed [17:0] y;
    int lat;
    write_coef(3'd0, 256);
    write_coef(3'd3, 0);
    do_flush();
    accept_sample(40);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 10'sd128;
    @(negedge clk); cfg_we = 1'b0;
    wait_out(y, lat);
    total++; if (y !== 18'sd40) begin bad++; $display("FAIL shadow_inflight got %0d expected 40", y); end
    accept_sample(40);
    wait_out(y, lat);
    total++; if (y !== 18'sd20) begin bad++; $display("FAIL shadow_next got %0d expected 20", y); end
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; data_in = 8'sd40; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 10'sd256;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; cfg_we = 1'b0;
    wait_out(y, lat);
    total++; if (y !== 18'sd20) begin bad++; $display("FAIL shadow_same_edge got %0d expected 20", y); end
    accept_sample(40);
    wait_out(y, lat);
    total++; if (y !== 18'sd40) begin bad++; $display("FAIL shadow_after_same_edge got %0d expected 40", y); end
  endtask

  task automatic test_flush();
    logic signed [17:0] first_y = 'x;
    int pulses = 0;
    accept_sample(77);
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 12; i++) begin if (out_valid) pulses++; @(negedge clk); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_drop got %0d pulses expected 0", pulses); end
    flush = 1'b1; in_valid = 1'b1; data_in = 8'sd55;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got %b expected 0", in_ready); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin if (out_valid) pulses++; @(negedge clk); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_no_accept got %0d pulses expected 0", pulses); end
    write_coef(3'd1, 256);
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; data_in = 8'sd10;
    @(posedge clk);
    @(negedge clk); data_in = 8'sd99;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) begin if (pulses == 0) first_y = data_out; pulses++; end
      @(negedge clk);
    end
    total++; if (first_y !== 18'sd10) begin bad++; $display("FAIL flush_hist_cleared got %0d expected 10", first_y); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL mac_valid_ignored got %0d pulses expected 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_feedback();
    test_saturation();
    test_coef_shadow();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
